// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the instruction-fetch slice.
// Holds the fetch buffer entry layout and the fetch sequencer state encoding.
package riscv_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0040_0000;
  localparam int          FETCH_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } t_fetch_entry;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_STALE
  } t_fetch_state;

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc,instr}; head is visible the cycle after push.
// Push/pop in the same cycle is legal at full; clear empties it in one edge.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [31:0]                push_pc,
  input  logic [31:0]                push_instr,
  input  logic                       pop,
  input  logic                       clear,
  output logic [31:0]                head_pc,
  output logic [31:0]                head_instr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  import riscv_pkg::*;

  localparam int AW = $clog2(DEPTH);

  t_fetch_entry mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  assign count      = wptr - rptr;
  assign empty      = (wptr == rptr);
  assign full       = (count == (AW+1)'(DEPTH));
  assign head_pc    = mem[rptr[AW-1:0]].pc;
  assign head_instr = mem[rptr[AW-1:0]].instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= {push_pc, push_instr};
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem req/gnt, buffers rvalid data; gnt at N -> if_valid_o at N+2.
// Requests stop while outstanding+buffered reaches FETCH_DEPTH; a raised request is never withdrawn.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = riscv_pkg::RESET_PC,
  parameter int          FETCH_DEPTH = riscv_pkg::FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        flush_o
);
  import riscv_pkg::*;

  localparam int CW = $clog2(FETCH_DEPTH) + 1;

  t_fetch_state  state;
  logic [31:0]   pc;
  logic [31:0]   target;
  logic [31:0]   rpc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic          req_hold;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] occ;
  logic          gnt_fire;
  logic          rv_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] out_next;
  logic [CW:0]   inflight;
  logic [31:0]   redirect_pc;

  assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign flush_o     = redirect_i;
  assign if_valid_o  = ~fifo_empty;
  assign imem_addr_o = pc;

  // The head leaving this cycle frees its slot, so a steady stream sustains one fetch per cycle.
  assign pop      = if_valid_o & ~stall_i & ~redirect_i;
  assign inflight = (CW+1)'(outstanding) + (CW+1)'(occ) - (CW+1)'(pop);

  assign imem_req_o = (state == FS_STALE) | req_hold |
                      ((state == FS_RUN) & (inflight < (CW+1)'(FETCH_DEPTH)));

  assign gnt_fire = imem_req_o & imem_gnt_i;
  assign rv_drop  = imem_rvalid_i & (drop != '0);
  assign push     = imem_rvalid_i & ~rv_drop & ~redirect_i;
  assign out_next = outstanding + CW'(gnt_fire) - CW'(imem_rvalid_i);

  fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (rpc),
    .push_instr (imem_rdata_i),
    .pop        (pop),
    .clear      (redirect_i),
    .head_pc    (if_pc_o),
    .head_instr (if_instr_o),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_BOOT;
      pc          <= RESET_PC;
      target      <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      req_hold    <= 1'b0;
    end else begin
      req_hold    <= imem_req_o & ~imem_gnt_i;
      outstanding <= out_next;
      // After a redirect every response still due belongs to the old stream.
      if (redirect_i) drop <= out_next;
      else            drop <= drop - CW'(rv_drop) + CW'((state == FS_STALE) & gnt_fire);
      if (redirect_i) rpc <= redirect_pc;
      else if (push)  rpc <= rpc + 32'd4;
      case (state)
        FS_BOOT: begin
          state <= FS_RUN;
          if (redirect_i) pc <= redirect_pc;
        end
        FS_RUN: begin
          if (redirect_i && imem_req_o && !imem_gnt_i) begin
            state  <= FS_STALE;
            target <= redirect_pc;
          end else if (redirect_i) begin
            pc <= redirect_pc;
          end else if (gnt_fire) begin
            pc <= pc + 32'd4;
          end
        end
        FS_STALE: begin
          if (redirect_i) target <= redirect_pc;
          if (imem_gnt_i) begin
            state <= FS_RUN;
            pc    <= redirect_i ? redirect_pc : target;
          end
        end
        default: state <= FS_BOOT;
      endcase
    end
  end

  a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (outstanding != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (!fifo_full || pop));

endmodule
